// File: rtl/skinny_sbox_layer_dom1_seq_if.sv
// Handshake and data bundle between the round-state register,
// the byte-serial sbox sequencer and the attached DOM-1 sbox8.
interface skinny_sbox_layer_dom1_seq_if #(
   parameter int NBYTES = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [8*NBYTES-1:0]   st0_i;
   logic [8*NBYTES-1:0]   st1_i;
   logic                  rnd_valid;
   logic                  rnd_ready;
   logic [7:0]            rnd_i;
   logic [7:0]            sb_si0;
   logic [7:0]            sb_si1;
   logic [7:0]            sb_r;
   logic [7:0]            sb_bo0;
   logic [7:0]            sb_bo1;
   logic                  out_valid;
   logic                  out_ready;
   logic [8*NBYTES-1:0]   st0_o;
   logic [8*NBYTES-1:0]   st1_o;

   modport slave (
      input  in_valid, st0_i, st1_i,
      input  rnd_valid, rnd_i,
      input  sb_bo0, sb_bo1,
      input  out_ready,
      output in_ready, rnd_ready,
      output sb_si0, sb_si1, sb_r,
      output out_valid, st0_o, st1_o
   );

   modport master (
      output in_valid, st0_i, st1_i,
      output rnd_valid, rnd_i,
      output sb_bo0, sb_bo1,
      output out_ready,
      input  in_ready, rnd_ready,
      input  sb_si0, sb_si1, sb_r,
      input  out_valid, st0_o, st1_o
   );
endinterface

// File: rtl/skinny_sbox_layer_dom1_seq.sv
// Byte-serial sequencer around a non-pipelined DOM-1 SKINNY sbox8:
// feeds one shared byte plus a fresh mask, holds it, collects output.
module skinny_sbox_layer_dom1_seq #(
   parameter int SBOX_LAT = 4,
   parameter int NBYTES   = 16
) (
   input logic clk,
   input logic rst_n,
   skinny_sbox_layer_dom1_seq_if.slave bus
);
   localparam int W  = 8 * NBYTES;
   localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int HW = $clog2(SBOX_LAT + 1);

   localparam logic [BW-1:0] BLAST = BW'(NBYTES - 1);
   localparam logic [HW-1:0] HMAX  = HW'(SBOX_LAT);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      DONE
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [BW-1:0] bcnt;
   logic [HW-1:0] hcnt;
   logic [W-1:0]  sh0;
   logic [W-1:0]  sh1;
   logic [7:0]    si0;
   logic [7:0]    si1;
   logic [7:0]    sr;
   logic          hold_end;

   assign hold_end = (hcnt == HMAX);

   // state register; reset aborts any byte in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // next state and Moore handshake outputs, all forced low in reset
   always_comb begin
      state_n       = state;
      bus.in_ready  = 1'b0;
      bus.rnd_ready = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            bus.in_ready = rst_n;
            if (bus.in_valid) state_n = FETCH;
         end
         FETCH: begin
            bus.rnd_ready = rst_n;
            if (bus.rnd_valid) state_n = HOLD;
         end
         HOLD: begin
            if (hold_end) begin
               state_n = (bcnt == BLAST) ? DONE : FETCH;
            end
         end
         DONE: begin
            bus.out_valid = rst_n;
            if (bus.out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // share registers, sbox operand registers and the two counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh0  <= '0;
         sh1  <= '0;
         si0  <= '0;
         si1  <= '0;
         sr   <= '0;
         bcnt <= '0;
         hcnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sh0  <= bus.st0_i;
                  sh1  <= bus.st1_i;
                  bcnt <= '0;
               end
            end
            FETCH: begin
               if (bus.rnd_valid) begin
                  si0  <= sh0[7:0];
                  si1  <= sh1[7:0];
                  sr   <= bus.rnd_i;
                  hcnt <= '0;
               end
            end
            HOLD: begin
               if (hold_end) begin
                  sh0  <= {bus.sb_bo0, sh0[W-1:8]};
                  sh1  <= {bus.sb_bo1, sh1[W-1:8]};
                  si0  <= '0;
                  si1  <= '0;
                  sr   <= '0;
                  bcnt <= bcnt + BW'(1);
               end else begin
                  hcnt <= hcnt + HW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  sh0 <= '0;
                  sh1 <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.sb_si0 = si0;
   assign bus.sb_si1 = si1;
   assign bus.sb_r   = sr;
   assign bus.st0_o  = sh0;
   assign bus.st1_o  = sh1;
endmodule

// File: tb/tb_skinny_sbox_layer_dom1_seq.sv
// Bench for the byte-serial sbox sequencer with a behavioural
// masked SKINNY sbox8 model of fixed latency.
module tb_skinny_sbox_layer_dom1_seq;
   localparam int NB  = 16;
   localparam int LAT = 4;
   localparam int W   = 8 * NB;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   skinny_sbox_layer_dom1_seq_if #(.NBYTES(NB)) bus ();

   skinny_sbox_layer_dom1_seq #(
      .SBOX_LAT(LAT),
      .NBYTES(NB)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // SKINNY-128 8-bit sbox from its mix/permute round definition
   function automatic logic [7:0] mix(input logic [7:0] x);
      logic [7:0] t;
      t = ~(((x >> 1) | x) >> 2);
      return (t & 8'h11) ^ x;
   endfunction

   function automatic logic [7:0] perm(input logic [7:0] x);
      return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) |
             ((x & 8'h20) >> 5) | ((x & 8'hC8) >> 2) |
             ((x & 8'h10) >> 1);
   endfunction

   function automatic logic [7:0] s8(input logic [7:0] a);
      logic [7:0] x;
      x = mix(a);
      x = mix(perm(x));
      x = mix(perm(x));
      x = mix(perm(x));
      return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
   endfunction

   // sbox model: LAT register levels, output shares XOR to S8(input)
   logic [7:0] p0 [LAT];
   logic [7:0] p1 [LAT];
   logic [7:0] pr [LAT];

   always @(posedge clk) begin
      p0[0] <= bus.sb_si0;
      p1[0] <= bus.sb_si1;
      pr[0] <= bus.sb_r;
      for (int i = 1; i < LAT; i++) begin
         p0[i] <= p0[i-1];
         p1[i] <= p1[i-1];
         pr[i] <= pr[i-1];
      end
   end

   assign bus.sb_bo1 = pr[LAT-1] ^ p0[LAT-1];
   assign bus.sb_bo0 = s8(p0[LAT-1] ^ p1[LAT-1]) ^ bus.sb_bo1;

   // handshake monitor: masks consumed, operand hold window
   int         hs_k = 0;
   int         hold_left = 0;
   bit         post = 1'b0;
   logic [W-1:0] cur_s0 = '0;
   logic [W-1:0] cur_s1 = '0;
   logic [7:0] e0, e1, er;
   logic [7:0] masks [$];

   always @(negedge clk) begin
      if (!rst_n) begin
         hs_k = 0;
         hold_left = 0;
         post = 1'b0;
         masks.delete();
      end else begin
         if (hold_left > 0) begin
            check("hold_si0", W'(bus.sb_si0), W'(e0));
            check("hold_si1", W'(bus.sb_si1), W'(e1));
            check("hold_r", W'(bus.sb_r), W'(er));
            check("hold_rdy", W'(bus.rnd_ready), '0);
            hold_left--;
            post = (hold_left == 0);
         end else if (post) begin
            check("sb_zero", W'({bus.sb_si0, bus.sb_si1, bus.sb_r}), '0);
            post = 1'b0;
         end
         if (bus.in_valid && bus.in_ready) begin
            hs_k = 0;
            masks.delete();
            cur_s0 = bus.st0_i;
            cur_s1 = bus.st1_i;
         end
         if (bus.rnd_valid && bus.rnd_ready) begin
            if (hs_k < NB) begin
               e0 = cur_s0[8*hs_k +: 8];
               e1 = cur_s1[8*hs_k +: 8];
            end
            er = bus.rnd_i;
            masks.push_back(bus.rnd_i);
            hs_k++;
            hold_left = LAT + 1;
         end
      end
   end

   function automatic logic [W-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_rdy"}, W'(bus.in_ready), W'(1));
      check({tag, "_out_v"}, W'(bus.out_valid), '0);
      check({tag, "_rnd_rdy"}, W'(bus.rnd_ready), '0);
      check({tag, "_sb"}, W'({bus.sb_si0, bus.sb_si1, bus.sb_r}), '0);
      check({tag, "_st0"}, bus.st0_o, '0);
      check({tag, "_st1"}, bus.st1_o, '0);
   endtask

   task automatic run_state(input logic [W-1:0] s0, input logic [W-1:0] s1,
                            input int stall_byte, input int abort_byte,
                            input int done_wait);
      int n;
      int stall_left;
      int abort_cnt;
      logic [W-1:0] x0;
      logic [W-1:0] x1;
      logic [7:0] m;
      stall_left = 3;
      abort_cnt = 0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.st0_i = s0;
      bus.st1_i = s1;
      bus.rnd_valid = 1'b1;
      bus.rnd_i = 8'($urandom);
      @(negedge clk);
      check("in_ready", W'(bus.in_ready), W'(1));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.st0_i = rnd128();
      bus.st1_i = rnd128();
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.out_valid || n >= 300) break;
         @(posedge clk);
         n++;
         #1;
         bus.rnd_i = 8'($urandom);
         bus.rnd_valid = 1'b1;
         if (stall_byte >= 0 && bus.rnd_ready && hs_k == stall_byte
             && stall_left > 0) begin
            bus.rnd_valid = 1'b0;
            stall_left--;
         end
         if (abort_byte >= 0 && hs_k == abort_byte + 1 && !bus.rnd_ready) begin
            abort_cnt++;
            if (abort_cnt == 2) begin
               rst_n = 1'b0;
               @(negedge clk);
               check("rst_in_rdy", W'(bus.in_ready), '0);
               check("rst_out_v", W'(bus.out_valid), '0);
               @(posedge clk);
               #1;
               rst_n = 1'b1;
               @(negedge clk);
               check_reset_vals("abort");
               return;
            end
         end
      end
      check("latency", W'(n), W'(96 + ((stall_byte >= 0) ? 3 : 0)));
      check("rnd_count", W'(masks.size()), W'(NB));
      for (int k = 0; k < NB; k++) begin
         m = (k < masks.size()) ? masks[k] : 8'h00;
         m = m ^ s0[8*k +: 8];
         x1[8*k +: 8] = m;
         x0[8*k +: 8] = s8(s0[8*k +: 8] ^ s1[8*k +: 8]) ^ m;
      end
      check("sbox_xor", bus.st0_o ^ bus.st1_o, x0 ^ x1);
      check("share0", bus.st0_o, x0);
      check("share1", bus.st1_o, x1);
      bus.out_ready = 1'b0;
      for (int i = 0; i < done_wait; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("done_valid", W'(bus.out_valid), W'(1));
         check("done_st0", bus.st0_o, x0);
         check("done_st1", bus.st1_o, x1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check_reset_vals("release");
   endtask

   logic [W-1:0] r0;
   logic [W-1:0] pt;

   initial begin
      bus.in_valid = 1'b0;
      bus.st0_i = '0;
      bus.st1_i = '0;
      bus.rnd_valid = 1'b0;
      bus.rnd_i = '0;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", W'(bus.in_ready), '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_reset_vals("idle");

      run_state('0, '0, -1, -1, 2);

      r0 = rnd128();
      run_state(r0, r0 ^ {NB{8'hFF}}, -1, -1, 2);

      for (int k = 0; k < NB; k++) pt[8*k +: 8] = 8'(k);
      r0 = rnd128();
      run_state(r0 ^ pt, r0, -1, -1, 20);

      run_state(rnd128(), rnd128(), 7, -1, 3);

      run_state(rnd128(), rnd128(), -1, 9, 0);
      run_state(rnd128(), rnd128(), -1, -1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/skinny_sbox_layer_dom1_seq.md
Name: skinny_sbox_layer_dom1_seq

Overview:
- Byte-serial sequencer directly upstream and downstream of the 4-cycle non-pipelined DOM-1 SKINNY sbox8.
- Accepts a 2-share 128-bit state and feeds the sbox one shared byte at a time, with one fresh 8-bit refresh mask per byte.
- Holds sbox inputs stable for the whole evaluation window, then collects the output shares back into a 2-share 128-bit result.
- Sits between the round-state register and the ShiftRows/MixColumns stage of the protected Romulus datapath.

Parameters:
- SBOX_LAT, 4, number of register levels inside the attached sbox8; hold window is SBOX_LAT+1 cycles.
- NBYTES, 16, bytes per state; the state width is 8*NBYTES.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input state valid.
- in_ready  out  1  block can accept a state.
- st0_i  in  8*NBYTES  input share 0.
- st1_i  in  8*NBYTES  input share 1.
- rnd_valid  in  1  fresh mask byte available.
- rnd_ready  out  1  block consumes a mask byte this cycle.
- rnd_i  in  8  fresh refresh mask.
- sb_si0  out  8  share 0 to sbox.
- sb_si1  out  8  share 1 to sbox.
- sb_r  out  8  refresh mask to sbox.
- sb_bo0  in  8  sbox output share 0.
- sb_bo1  in  8  sbox output share 1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- st0_o  out  8*NBYTES  result share 0.
- st1_o  out  8*NBYTES  result share 1.

Behaviour:
- Byte k occupies bits [8k+7:8k] of each share. Bytes are processed in order k = 0..NBYTES-1.
- State registers sh0/sh1 (8*NBYTES each) drive st0_o/st1_o directly.
- sb_si0, sb_si1 and sb_r are registered outputs.
- Reset (rst_n=0 at a posedge):
  - state = IDLE; byte counter and hold counter = 0.
  - sh0, sh1, sb_si0, sb_si1, sb_r = 0.
  - in_ready=0 during reset, 1 in the first cycle after.
  - rnd_ready=0, out_valid=0.
  - Reset mid-operation aborts immediately: no partial result is emitted and the consumed masks are discarded.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid: load sh0<=st0_i, sh1<=st1_i, byte counter <= 0, go to FETCH.
  - FETCH:
    - rnd_ready=1; sb_* registers hold 0.
    - On rnd_valid: sb_si0<=sh0[7:0], sb_si1<=sh1[7:0], sb_r<=rnd_i, hold counter <= 0, go to HOLD.
    - While rnd_valid=0: stall in FETCH with no other change.
  - HOLD:
    - sb_si0, sb_si1 and sb_r are constant for exactly SBOX_LAT+1 cycles.
    - The hold counter increments 0..SBOX_LAT.
    - At the edge ending the cycle with counter==SBOX_LAT:
      - sh0 <= {sb_bo0, sh0[8*NBYTES-1:8]} and sh1 <= {sb_bo1, sh1[8*NBYTES-1:8]}, i.e. shift right one byte, output byte enters at the top.
      - sb_si0, sb_si1, sb_r <= 0.
      - Byte counter increments.
      - If the byte just captured was NBYTES-1, go to DONE; otherwise go to FETCH.
    - After NBYTES shifts, output byte k sits at its original position k.
  - DONE:
    - out_valid=1; sh0/sh1 are frozen.
    - On out_ready: sh0, sh1 <= 0 and go to IDLE.
    - in_ready stays 0 until IDLE, so there is no same-cycle accept.
- Timing with rnd_valid held 1:
  - (SBOX_LAT+2) cycles per byte.
  - out_valid is first high 96 cycles after the in handshake edge (NBYTES=16, SBOX_LAT=4).
  - Each rnd_valid stall cycle adds exactly one cycle.
- Masking rules:
  - Shares are never XORed together inside this block.
  - sb_* registers are zero outside HOLD to avoid transitional share leakage.
  - A mask is never reused: exactly one rnd handshake per byte, NBYTES per state.
- The byte counter is $clog2(NBYTES) bits; the last-byte test is an explicit compare against NBYTES-1, not a reliance on wrap-around.

Test Plan:
- Reset, then idle for 10 cycles -> in_ready=1; out_valid=0; rnd_ready=0; sb_si0=sb_si1=sb_r=0; st0_o=st1_o=0.
- st0_i=0, st1_i=0, rnd_valid held 1 with random rnd_i -> out_valid at edge +96; every byte of st0_o^st1_o = 0x65. With st0_i^st1_i = all 0xFF -> all bytes 0xFF.
- Random shares with distinct plaintext bytes 0x00..0x0F -> byte k of (st0_o^st1_o) = S8(k), position preserved. Exactly 16 rnd handshakes. sb_* constant across each 5-cycle HOLD, checked by assertion.
- rnd_valid deasserted for 3 cycles before byte 7 -> FETCH stalls, out_valid at edge +99, result unchanged.
- out_ready held 0 for 20 cycles in DONE -> st0_o/st1_o stable and out_valid high throughout. Then out_ready=1 -> IDLE next cycle with sh0=sh1=0.
- rst_n=0 during HOLD of byte 9 -> next cycle IDLE, all outputs at reset values. A new state then completes correctly in 96 cycles.
